// File: rtl/memif_pkg.sv
// Shared definitions for the ICB burst memory interface: FSM state encoding,
// the ICB transfer size code and the default parameter values.
package memif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } memif_state_e;

    // ICB size code for a full 32-bit word transfer.
    localparam logic [1:0] ICB_SIZE_WORD = 2'b10;

    localparam int MEMIF_AW        = 32;
    localparam int MEMIF_DW        = 32;
    localparam int MEMIF_MAX_OUTST = 4;
    localparam int MEMIF_NUM_CH    = 4;
    localparam int MEMIF_LEN_W     = 16;

endpackage

// File: rtl/memif_rsp_fifo.sv
// Read-response buffer: synchronous FIFO, DEPTH a power of two, storage and
// pointers cleared by the asynchronous active-low reset. Pushes when full and
// pops when empty are ignored.
module memif_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          nice_clk,
    input  logic          nice_rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [PW:0]   count
);

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;

    logic do_push;
    logic do_pop;

    assign do_push = push && (cnt != FULL_CNT);
    assign do_pop  = pop && (cnt != '0);

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign count = cnt;

    // Storage, pointers and occupancy count.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW + 1)'(1);
                2'b01:   cnt <= cnt - (PW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/icb_burst_memif.sv
// ICB burst memory interface: turns one burst request (base, length, stride)
// into a sequence of single-word ICB commands, tracks outstanding commands,
// buffers read responses and streams them out with a channel tag and last flag.
// Build option: define MEMIF_ERR_ABORT_EN to stop issuing commands after the
// first errored response; by default a burst always runs to completion.
//
// Handshake rule on every valid/ready pair: a transfer happens on the rising
// clock edge where both valid and ready are 1; valid never waits on ready.
module icb_burst_memif
    import memif_pkg::*;
#(
    parameter int AW        = MEMIF_AW,
    parameter int DW        = MEMIF_DW,
    parameter int MAX_OUTST = MEMIF_MAX_OUTST,
    parameter int NUM_CH    = MEMIF_NUM_CH,
    parameter int LEN_W     = MEMIF_LEN_W
) (
    input  logic                      nice_clk,
    input  logic                      nice_rst_n,
    output logic                      nice_icb_cmd_valid,
    input  logic                      nice_icb_cmd_ready,
    output logic [AW-1:0]             nice_icb_cmd_addr,
    output logic                      nice_icb_cmd_read,
    output logic [DW-1:0]             nice_icb_cmd_wdata,
    output logic [1:0]                nice_icb_cmd_size,
    input  logic                      nice_icb_rsp_valid,
    output logic                      nice_icb_rsp_ready,
    input  logic [DW-1:0]             nice_icb_rsp_rdata,
    input  logic                      nice_icb_rsp_err,
    output logic                      nice_mem_holdup,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(NUM_CH)-1:0] req_ch,
    input  logic                      req_write,
    input  logic [AW-1:0]             req_base,
    input  logic [LEN_W-1:0]          req_len,
    input  logic [AW-1:0]             req_stride,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DW-1:0]             rd_data,
    output logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic                      rd_last,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DW-1:0]             wr_data,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output memif_state_e              dbg_state
);

    localparam int CW = $clog2(NUM_CH);
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

    memif_state_e   state_q;
    memif_state_e   state_d;
    logic           holdup_q;

    logic [CW-1:0]    ch_q;
    logic             wr_q;
    logic [LEN_W-1:0] len_q;
    logic [AW-1:0]    stride_q;
    logic [AW-1:0]    addr_q;
    logic [LEN_W-1:0] issue_cnt_q;
    logic [LEN_W-1:0] rsp_cnt_q;
    logic [OW-1:0]    outst_q;
    logic             err_q;
    logic             abort_q;

    logic          req_accept;
    logic          issue_ok;
    logic          rd_space;
    logic          cmd_hs;
    logic          rsp_hs;
    logic          err_hit;
    logic          last_flag;
    logic          fifo_push;
    logic          fifo_pop;
    logic [DW:0]   fifo_din;
    logic [DW:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [OW-1:0] fifo_count;
    logic [OW-1:0] fifo_free;

    assign req_accept = (state_q == ST_IDLE) && req_valid;

    // A read command may only go out if every outstanding response plus this
    // one is guaranteed a FIFO slot, so responses are never refused for space.
    assign fifo_free = MAX_O - fifo_count;
    assign rd_space  = (fifo_free > outst_q);
    assign issue_ok  = (state_q == ST_ISSUE) && !abort_q &&
                       (issue_cnt_q != len_q) && (outst_q < MAX_O);

    assign nice_icb_cmd_valid = issue_ok && (wr_q ? wr_valid : rd_space);
    assign wr_ready           = issue_ok && wr_q && nice_icb_cmd_ready;
    assign cmd_hs             = nice_icb_cmd_valid && nice_icb_cmd_ready;

    assign nice_icb_cmd_addr  = addr_q;
    assign nice_icb_cmd_read  = busy && !wr_q;
    assign nice_icb_cmd_wdata = (nice_icb_cmd_valid && wr_q) ? wr_data : '0;
    assign nice_icb_cmd_size  = busy ? ICB_SIZE_WORD : 2'b00;

    assign nice_icb_rsp_ready = busy && (wr_q || !fifo_full);
    assign rsp_hs             = nice_icb_rsp_valid && nice_icb_rsp_ready;

`ifdef MEMIF_ERR_ABORT_EN
    assign err_hit = rsp_hs && nice_icb_rsp_err;
`else
    assign err_hit = 1'b0;
`endif

    // A truncated burst never reaches its final word, so last is suppressed.
    assign last_flag = (rsp_cnt_q == (len_q - LEN_W'(1))) && !abort_q;
    assign fifo_push = rsp_hs && !wr_q;
    assign fifo_din  = {last_flag, nice_icb_rsp_rdata};
    assign fifo_pop  = rd_valid && rd_ready;

    memif_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (MAX_OUTST)
    ) u_rsp_fifo (
        .nice_clk   (nice_clk),
        .nice_rst_n (nice_rst_n),
        .push       (fifo_push),
        .din        (fifo_din),
        .pop        (fifo_pop),
        .dout       (fifo_dout),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = rd_valid ? fifo_dout[DW-1:0] : '0;
    assign rd_last  = rd_valid && fifo_dout[DW];
    assign rd_ch    = rd_valid ? ch_q : '0;

    assign req_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign err             = err_q;
    assign nice_mem_holdup = holdup_q;
    assign dbg_state       = state_q;

    // Next-state selection for the burst sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    state_d = (req_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort_q || err_hit) begin
                    state_d = ST_DRAIN;
                end else if (cmd_hs && ((issue_cnt_q + LEN_W'(1)) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with the registered holdup output that mirrors it.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            state_q  <= ST_IDLE;
            holdup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            holdup_q <= (state_d != ST_IDLE);
        end
    end

    // Burst context, address accumulator, counters and error flags.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            ch_q        <= '0;
            wr_q        <= 1'b0;
            len_q       <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            if (req_accept) begin
                ch_q        <= req_ch;
                wr_q        <= req_write;
                len_q       <= req_len;
                stride_q    <= req_stride;
                addr_q      <= req_base;
                issue_cnt_q <= '0;
                rsp_cnt_q   <= '0;
                err_q       <= 1'b0;
                abort_q     <= 1'b0;
            end else begin
                if (cmd_hs) begin
                    addr_q      <= addr_q + stride_q;
                    issue_cnt_q <= issue_cnt_q + LEN_W'(1);
                end
                if (rsp_hs) begin
                    rsp_cnt_q <= rsp_cnt_q + LEN_W'(1);
                    if (nice_icb_rsp_err) begin
                        err_q <= 1'b1;
                    end
                end
                if (err_hit) begin
                    abort_q <= 1'b1;
                end
            end
            case ({cmd_hs, rsp_hs})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

endmodule

// File: tb/tb_icb_burst_memif.sv
// Directed bench for icb_burst_memif with a small ICB slave (one-cycle
// response latency, read data = address ^ 0x5A5A0000), a write-data source
// and a read sink. Inputs are driven at the falling edge; handshakes are
// sampled 1 time unit later, before the next rising edge.
module tb_icb_burst_memif;
  import memif_pkg::*;

  logic        nice_clk;
  logic        nice_rst_n;
  logic        nice_icb_cmd_valid;
  logic        nice_icb_cmd_ready;
  logic [31:0] nice_icb_cmd_addr;
  logic        nice_icb_cmd_read;
  logic [31:0] nice_icb_cmd_wdata;
  logic [1:0]  nice_icb_cmd_size;
  logic        nice_icb_rsp_valid;
  logic        nice_icb_rsp_ready;
  logic [31:0] nice_icb_rsp_rdata;
  logic        nice_icb_rsp_err;
  logic        nice_mem_holdup;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ch;
  logic        req_write;
  logic [31:0] req_base;
  logic [15:0] req_len;
  logic [31:0] req_stride;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_ch;
  logic        rd_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        done;
  logic        err;
  logic        busy;
  memif_state_e dbg_state;

  icb_burst_memif dut (
    .nice_clk           (nice_clk),
    .nice_rst_n         (nice_rst_n),
    .nice_icb_cmd_valid (nice_icb_cmd_valid),
    .nice_icb_cmd_ready (nice_icb_cmd_ready),
    .nice_icb_cmd_addr  (nice_icb_cmd_addr),
    .nice_icb_cmd_read  (nice_icb_cmd_read),
    .nice_icb_cmd_wdata (nice_icb_cmd_wdata),
    .nice_icb_cmd_size  (nice_icb_cmd_size),
    .nice_icb_rsp_valid (nice_icb_rsp_valid),
    .nice_icb_rsp_ready (nice_icb_rsp_ready),
    .nice_icb_rsp_rdata (nice_icb_rsp_rdata),
    .nice_icb_rsp_err   (nice_icb_rsp_err),
    .nice_mem_holdup    (nice_mem_holdup),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_ch             (req_ch),
    .req_write          (req_write),
    .req_base           (req_base),
    .req_len            (req_len),
    .req_stride         (req_stride),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_data            (rd_data),
    .rd_ch              (rd_ch),
    .rd_last            (rd_last),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_data            (wr_data),
    .done               (done),
    .err                (err),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  initial nice_clk = 1'b0;
  always #5 nice_clk = ~nice_clk;

  int checks = 0;
  int failures = 0;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] cmd_addr_log[$];
  logic        cmd_read_log[$];
  logic [31:0] cmd_wdata_log[$];
  logic [1:0]  cmd_size_log[$];
  logic [31:0] rd_data_log[$];
  logic        rd_last_log[$];
  logic [1:0]  rd_ch_log[$];
  logic [31:0] pend_addr_q[$];
  logic        pend_err_q[$];
  logic [31:0] wr_vals[$];

  bit cmd_ready_en = 1'b1;
  bit rd_ready_en  = 1'b1;
  bit req_pend     = 1'b0;
  int err_idx      = -1;
  int cmd_in_burst = 0;
  int cmd_valid_seen = 0;
  int rsp_hs_cnt   = 0;
  int done_cnt     = 0;
  int done_cyc     = 0;
  int accept_cyc   = 0;
  int rsp_at_done  = 0;
  int cyc          = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // driver: one clock cycle of slave, sources and sinks
  task automatic tick();
    @(negedge nice_clk);
    nice_icb_cmd_ready = cmd_ready_en;
    if (pend_addr_q.size() > 0) begin
      nice_icb_rsp_valid = 1'b1;
      nice_icb_rsp_rdata = mem_word(pend_addr_q[0]);
      nice_icb_rsp_err   = pend_err_q[0];
    end else begin
      nice_icb_rsp_valid = 1'b0;
      nice_icb_rsp_rdata = 32'h0;
      nice_icb_rsp_err   = 1'b0;
    end
    wr_valid  = (wr_vals.size() > 0);
    wr_data   = (wr_vals.size() > 0) ? wr_vals[0] : 32'h0;
    rd_ready  = rd_ready_en;
    req_valid = req_pend;
    #1;
    if (req_valid && req_ready) begin
      req_pend = 1'b0;
      accept_cyc = cyc;
    end
    if (nice_icb_rsp_valid && nice_icb_rsp_ready) begin
      void'(pend_addr_q.pop_front());
      void'(pend_err_q.pop_front());
      rsp_hs_cnt++;
    end
    if (nice_icb_cmd_valid) cmd_valid_seen++;
    if (nice_icb_cmd_valid && nice_icb_cmd_ready) begin
      cmd_addr_log.push_back(nice_icb_cmd_addr);
      cmd_read_log.push_back(nice_icb_cmd_read);
      cmd_wdata_log.push_back(nice_icb_cmd_wdata);
      cmd_size_log.push_back(nice_icb_cmd_size);
      pend_addr_q.push_back(nice_icb_cmd_addr);
      pend_err_q.push_back(cmd_in_burst == err_idx);
      cmd_in_burst++;
    end
    if (wr_valid && wr_ready) void'(wr_vals.pop_front());
    if (rd_valid && rd_ready) begin
      rd_data_log.push_back(rd_data);
      rd_last_log.push_back(rd_last);
      rd_ch_log.push_back(rd_ch);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      rsp_at_done = rsp_hs_cnt;
    end
    cyc++;
  endtask

  task automatic start_burst(input logic [1:0] ch, input logic wr, input logic [31:0] base,
                             input logic [15:0] len, input logic [31:0] stride);
    req_ch = ch; req_write = wr; req_base = base; req_len = len; req_stride = stride;
    req_pend = 1'b1;
    exp_q.delete(); cmd_addr_log.delete(); cmd_read_log.delete(); cmd_wdata_log.delete();
    cmd_size_log.delete(); rd_data_log.delete(); rd_last_log.delete(); rd_ch_log.delete();
    cmd_in_burst = 0; cmd_valid_seen = 0; rsp_hs_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, (done_cnt != start), 1'b1);
    repeat (3) tick();
    check_eq({tag, "_done_once"}, done_cnt - start, 1);
  endtask

  task automatic check_reads(input string tag, input int last_idx, input logic [1:0] ch);
    int bad_ch = 0;
    check_eq({tag, "_rd_count"}, rd_data_log.size(), exp_q.size());
    for (int i = 0; i < rd_data_log.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_rd%0d", tag, i), rd_data_log[i], exp_q[i]);
      check_eq($sformatf("%s_last%0d", tag, i), rd_last_log[i], (i == last_idx));
      if (rd_ch_log[i] !== ch) bad_ch++;
    end
    check_eq({tag, "_rd_ch_errs"}, bad_ch, 0);
  endtask

  task automatic check_addrs(input string tag, input logic [31:0] base, input logic [31:0] stride,
                             input int n, input logic rd);
    logic [31:0] a = base;
    check_eq({tag, "_cmd_count"}, cmd_addr_log.size(), n);
    for (int i = 0; i < n && i < cmd_addr_log.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), cmd_addr_log[i], a);
      check_eq($sformatf("%s_read%0d", tag, i), cmd_read_log[i], rd);
      a = a + stride;
    end
  endtask

  initial begin
    nice_rst_n = 1'b0;
    nice_icb_cmd_ready = 1'b0; nice_icb_rsp_valid = 1'b0; nice_icb_rsp_rdata = 32'h0;
    nice_icb_rsp_err = 1'b0; req_valid = 1'b0; req_ch = 2'd0; req_write = 1'b0;
    req_base = 32'h0; req_len = 16'h0; req_stride = 32'h0; rd_ready = 1'b0;
    wr_valid = 1'b0; wr_data = 32'h0;

    // reset values
    repeat (3) @(negedge nice_clk);
    #1;
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_busy_holdup_done_err", {busy, nice_mem_holdup, done, err}, 4'b0000);
    check_eq("rst_cmd_rsp", {nice_icb_cmd_valid, nice_icb_rsp_ready, nice_icb_cmd_size}, 4'b0000);
    check_eq("rst_rd_wr", {rd_valid, rd_last, wr_ready}, 3'b000);
    check_eq("rst_state", dbg_state, ST_IDLE);
    @(negedge nice_clk);
    nice_rst_n = 1'b1;

    // read burst: base 0x1000, len 4, stride 4
    start_burst(2'd2, 1'b0, 32'h1000, 16'd4, 32'd4);
    exp_q.push_back(mem_word(32'h1000)); exp_q.push_back(mem_word(32'h1004));
    exp_q.push_back(mem_word(32'h1008)); exp_q.push_back(mem_word(32'h100C));
    wait_done("rd4", 100);
    check_addrs("rd4", 32'h1000, 32'd4, 4, 1'b1);
    check_eq("rd4_size", cmd_size_log.size() > 0 ? cmd_size_log[0] : 2'b00, 2'b10);
    check_reads("rd4", 3, 2'd2);
    check_eq("rd4_idle_busy", busy, 1'b0);

    // backpressure: rd_ready low, len 8
    rd_ready_en = 1'b0;
    start_burst(2'd1, 1'b0, 32'h3000, 16'd8, 32'd8);
    for (int k = 0; k < 8; k++) exp_q.push_back(mem_word(32'h3000 + 32'(k * 8)));
    repeat (20) tick();
    check_eq("bp_cmds_le_max", cmd_addr_log.size() <= 4, 1'b1);
    check_eq("bp_cmds_nonzero", cmd_addr_log.size() > 0, 1'b1);
    check_eq("bp_no_rd", rd_data_log.size(), 0);
    check_eq("bp_holdup", nice_mem_holdup, 1'b1);
    rd_ready_en = 1'b1;
    wait_done("bp", 200);
    check_addrs("bp", 32'h3000, 32'd8, 8, 1'b1);
    check_reads("bp", 7, 2'd1);

    // write burst: len 3, stride 0x40
    start_burst(2'd0, 1'b1, 32'h2000, 16'd3, 32'h40);
    wr_vals.push_back(32'hAAAA_0001); wr_vals.push_back(32'hBBBB_0002); wr_vals.push_back(32'hCCCC_0003);
    wait_done("wr3", 100);
    check_addrs("wr3", 32'h2000, 32'h40, 3, 1'b0);
    check_eq("wr3_wdata0", cmd_wdata_log.size() > 0 ? cmd_wdata_log[0] : 32'h0, 32'hAAAA_0001);
    check_eq("wr3_wdata1", cmd_wdata_log.size() > 1 ? cmd_wdata_log[1] : 32'h0, 32'hBBBB_0002);
    check_eq("wr3_wdata2", cmd_wdata_log.size() > 2 ? cmd_wdata_log[2] : 32'h0, 32'hCCCC_0003);
    check_eq("wr3_rsp_at_done", rsp_at_done, 3);
    check_eq("wr3_no_rd", rd_data_log.size(), 0);

    // error on word 2 of a len-6 read
    start_burst(2'd3, 1'b0, 32'h4000, 16'd6, 32'd4);
    err_idx = 2;
    wait_done("er6", 200);
    err_idx = -1;
    check_eq("er6_err", err, 1'b1);
`ifdef MEMIF_ERR_ABORT_EN
    check_eq("er6_truncated", cmd_addr_log.size() < 6, 1'b1);
    for (int k = 0; k < cmd_addr_log.size(); k++) exp_q.push_back(mem_word(32'h4000 + 32'(k * 4)));
    check_reads("er6", -1, 2'd3);
`else
    for (int k = 0; k < 6; k++) exp_q.push_back(mem_word(32'h4000 + 32'(k * 4)));
    check_addrs("er6", 32'h4000, 32'd4, 6, 1'b1);
    check_reads("er6", 5, 2'd3);
`endif
    repeat (2) tick();
    check_eq("er6_sticky", err, 1'b1);

    // zero-length burst
    start_burst(2'd0, 1'b0, 32'h5000, 16'd0, 32'd4);
    wait_done("len0", 10);
    check_eq("len0_no_cmd", cmd_valid_seen, 0);
    check_eq("len0_gap_ok", (done_cyc - accept_cyc >= 1) && (done_cyc - accept_cyc <= 2), 1'b1);
    check_eq("len0_err_cleared", err, 1'b0);

    // reset while issuing
    start_burst(2'd1, 1'b0, 32'h7000, 16'd8, 32'd4);
    repeat (3) tick();
    check_eq("rst_mid_in_issue", dbg_state, ST_ISSUE);
    @(negedge nice_clk);
    nice_rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ready_busy", {req_ready, busy, nice_mem_holdup, done}, 4'b1000);
    check_eq("rst_mid_cmd_rd", {nice_icb_cmd_valid, nice_icb_rsp_ready, rd_valid, err}, 4'b0000);
    pend_addr_q.delete(); pend_err_q.delete(); req_pend = 1'b0;
    @(negedge nice_clk);
    nice_rst_n = 1'b1;

    // post-reset burst with address wrap: base 4, stride -4
    start_burst(2'd2, 1'b0, 32'h0000_0004, 16'd4, 32'hFFFF_FFFC);
    exp_q.push_back(mem_word(32'h0000_0004)); exp_q.push_back(mem_word(32'h0000_0000));
    exp_q.push_back(mem_word(32'hFFFF_FFFC)); exp_q.push_back(mem_word(32'hFFFF_FFF8));
    wait_done("wrap", 100);
    check_addrs("wrap", 32'h0000_0004, 32'hFFFF_FFFC, 4, 1'b1);
    check_reads("wrap", 3, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
